// File: rtl/opc5ls_bus_responder.sv
// opc5ls bus responder: async-read RAM, interval timer with interrupt,
// and a clock-enable wait-state generator for the CPU memory bus.
module opc5ls_bus_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] IO_BASE     = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] address,
    input  logic [15:0] cpu_dout,
    input  logic        rnw,
    input  logic        vpa,
    input  logic        vda,
    output logic [15:0] cpu_din,
    output logic        clken,
    output logic        int_b
);

    localparam int RAM_WORDS = 1 << ADDR_WIDTH;

    logic        access;
    logic        is_ram;
    logic        is_io;
    logic        wr_en;
    logic        io_wr;
    logic        expire;
    logic [15:0] reg_rd;

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic        run_q, run_d;
    logic        irq_en_q, irq_en_d;
    logic        pending_q, pending_d;
    logic        int_b_q, int_b_d;

    logic [15:0] ram_q [RAM_WORDS];

    assign access = vpa | vda;
    assign is_ram = {1'b0, address} < 17'(RAM_WORDS);
    // RAM takes priority if a wide RAM ever overlaps the timer block
    assign is_io  = !is_ram && (address[15:2] == IO_BASE[15:2]);
    assign clken  = !access || (wait_cnt_q == 4'(WAIT_STATES));
    assign wr_en  = access && !rnw && clken;
    assign io_wr  = wr_en && is_io;
    assign expire = run_q && (count_q == 16'h0000);
    assign int_b  = int_b_q;

    always_comb begin
        wait_cnt_d = clken ? 4'd0 : wait_cnt_q + 4'd1;
    end

    always_comb begin
        reload_d  = reload_q;
        count_d   = count_q;
        run_d     = run_q;
        irq_en_d  = irq_en_q;
        pending_d = pending_q;
        if (expire) begin
            count_d   = reload_q;
            pending_d = 1'b1;
        end else if (run_q) begin
            count_d = count_q - 16'd1;
        end
        if (io_wr) begin
            case (address[1:0])
                2'd0: begin
                    reload_d = cpu_dout;
                    count_d  = cpu_dout;
                end
                2'd2: begin
                    run_d    = cpu_dout[0];
                    irq_en_d = cpu_dout[1];
                end
                2'd3: begin
                    if (cpu_dout[0] && !expire) pending_d = 1'b0;
                end
                default: ;
            endcase
        end
        int_b_d = !(pending_q && irq_en_q);
    end

    always_comb begin
        reg_rd = 16'h0000;
        case (address[1:0])
            2'd0:    reg_rd = reload_q;
            2'd1:    reg_rd = count_q;
            2'd2:    reg_rd = {14'h0000, irq_en_q, run_q};
            default: reg_rd = {15'h0000, pending_q};
        endcase
    end

    always_comb begin
        cpu_din = 16'h0000;
        if (access) begin
            unique case (1'b1)
                is_ram:  cpu_din = ram_q[address[ADDR_WIDTH-1:0]];
                is_io:   cpu_din = reg_rd;
                default: cpu_din = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && is_ram) begin
            ram_q[address[ADDR_WIDTH-1:0]] <= cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wait_cnt_q <= 4'd0;
            reload_q   <= 16'h0000;
            count_q    <= 16'h0000;
            run_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            int_b_q    <= 1'b1;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            run_q      <= run_d;
            irq_en_q   <= irq_en_d;
            pending_q  <= pending_d;
            int_b_q    <= int_b_d;
        end
    end

endmodule

// File: tb/tb_opc5ls_bus_responder.sv
// Bench for opc5ls_bus_responder: three instances (0, 3 and 2 wait states)
// share one stimulus bus; each scenario resets and checks one instance.
module tb_opc5ls_bus_responder;

    localparam logic [15:0] IOB = 16'hFFF0;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [15:0] cpu_dout = 16'h0000;
    logic        rnw = 1'b1;
    logic        vpa = 1'b0;
    logic        vda = 1'b0;

    logic [15:0] din0, din3, din2;
    logic        ce0, ce3, ce2;
    logic        ib0, ib3, ib2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    opc5ls_bus_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset_b(reset_b), .address(address), .cpu_dout(cpu_dout),
        .rnw(rnw), .vpa(vpa), .vda(vda),
        .cpu_din(din0), .clken(ce0), .int_b(ib0));

    opc5ls_bus_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset_b(reset_b), .address(address), .cpu_dout(cpu_dout),
        .rnw(rnw), .vpa(vpa), .vda(vda),
        .cpu_din(din3), .clken(ce3), .int_b(ib3));

    opc5ls_bus_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset_b(reset_b), .address(address), .cpu_dout(cpu_dout),
        .rnw(rnw), .vpa(vpa), .vda(vda),
        .cpu_din(din2), .clken(ce2), .int_b(ib2));

    task automatic put(input logic [15:0] a, input logic [15:0] d,
                       input logic wr, input logic p, input logic da);
        address  = a;
        cpu_dout = d;
        rnw      = !wr;
        vpa      = p;
        vda      = da;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        put(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        reset_b = 1'b0;
        step();
        reset_b = 1'b1;
    endtask

    task automatic test_reset();
        reset_all();
        put(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        checks++; if (ib0 !== 1'b1 || ib3 !== 1'b1 || ib2 !== 1'b1) begin errors++; $display("FAIL rst_int_b got %b%b%b want 111", ib0, ib3, ib2); end
        checks++; if (ce0 !== 1'b1 || ce3 !== 1'b1 || ce2 !== 1'b1) begin errors++; $display("FAIL rst_clken got %b%b%b want 111", ce0, ce3, ce2); end
        for (int r = 0; r < 4; r++) begin
            put(IOB + 16'(r), 16'h0000, 1'b0, 1'b0, 1'b1);
            checks++; if (din0 !== 16'h0000) begin errors++; $display("FAIL rst_reg%0d got %h want 0000", r, din0); end
            step();
        end
    endtask

    task automatic test_ram_ws0();
        logic [15:0] ram_m [int];
        logic [15:0] addrs [16];
        logic [15:0] a, d;
        reset_all();
        put(16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        checks++; if (ce0 !== 1'b1) begin errors++; $display("FAIL ws0_wr_clken got %b want 1", ce0); end
        step();
        put(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++; if (ce0 !== 1'b1) begin errors++; $display("FAIL ws0_rd_clken got %b want 1", ce0); end
        checks++; if (din0 !== 16'hBEEF) begin errors++; $display("FAIL ws0_rd_beef got %h want beef", din0); end
        step();
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom_range(0, 4095));
            d = 16'($urandom);
            addrs[i] = a;
            ram_m[int'(a)] = d;
            if ($urandom_range(0, 1) == 1) put(a, d, 1'b1, 1'b1, 1'b0);
            else put(a, d, 1'b1, 1'b0, 1'b1);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            a = addrs[$urandom_range(0, 15)];
            put(a, 16'h0000, 1'b0, 1'b1, 1'b0);
            checks++; if (din0 !== ram_m[int'(a)]) begin errors++; $display("FAIL ws0_rand_rd addr %h got %h want %h", a, din0, ram_m[int'(a)]); end
            step();
        end
        put(addrs[0], 16'h0000, 1'b0, 1'b0, 1'b0);
        checks++; if (din0 !== 16'h0000 || ce0 !== 1'b1) begin errors++; $display("FAIL ws0_idle got din %h ce %b want 0000 1", din0, ce0); end
        step();
    endtask

    task automatic test_wait_states();
        localparam int WS = 3;
        logic [15:0] a, d;
        reset_all();
        for (int i = 0; i <= WS; i++) begin
            put(16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b1);
            checks++; if (ce3 !== (i == WS)) begin errors++; $display("FAIL ws3_wr_ce[%0d] got %b want %b", i, ce3, i == WS); end
            step();
        end
        for (int i = 0; i <= WS; i++) begin
            put(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1);
            checks++; if (ce3 !== (i == WS) || din3 !== 16'hBEEF) begin errors++; $display("FAIL ws3_rd[%0d] got ce %b din %h want %b beef", i, ce3, din3, i == WS); end
            step();
        end
        for (int i = 0; i <= WS; i++) begin
            put(16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0);
            checks++; if (ce3 !== (i == WS)) begin errors++; $display("FAIL ws3_b2b_ce[%0d] got %b want %b", i, ce3, i == WS); end
            step();
        end
        for (int i = 0; i < int'($urandom_range(1, WS)); i++) begin
            put(16'h0010, 16'h5555, 1'b1, 1'b0, 1'b1);
            step();
        end
        put(16'h0010, 16'h5555, 1'b0, 1'b0, 1'b0);
        checks++; if (ce3 !== 1'b1) begin errors++; $display("FAIL ws3_idle_ce got %b want 1", ce3); end
        step();
        for (int i = 0; i <= WS; i++) begin
            put(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1);
            if (i == WS) begin
                checks++; if (din3 !== 16'hBEEF) begin errors++; $display("FAIL ws3_abort_wr got %h want beef", din3); end
            end
            step();
        end
        a = 16'($urandom_range(32, 4095));
        d = 16'($urandom);
        for (int i = 0; i <= WS; i++) begin put(a, d, 1'b1, 1'b0, 1'b1); step(); end
        for (int i = 0; i <= WS; i++) begin
            put(a, 16'h0000, 1'b0, 1'b1, 1'b0);
            if (i == WS) begin
                checks++; if (din3 !== d) begin errors++; $display("FAIL ws3_rand_wr addr %h got %h want %h", a, din3, d); end
            end
            step();
        end
    endtask

    task automatic test_timer(input int r, input logic [1:0] ctrl);
        int n;
        logic [15:0] cnt_exp;
        logic        ib_exp;
        reset_all();
        put(IOB, 16'(r), 1'b1, 1'b0, 1'b1);
        step();
        put(IOB + 16'd2, {14'h0000, ctrl}, 1'b1, 1'b0, 1'b1);
        step();
        n = 3 * (r + 1) + 3;
        for (int k = 0; k < n; k++) begin
            cnt_exp = 16'(r - (k % (r + 1)));
            ib_exp  = !(ctrl[1] && k >= r + 2);
            put(IOB + 16'd1, 16'h0000, 1'b0, 1'b0, 1'b1);
            checks++; if (din0 !== cnt_exp || ib0 !== ib_exp) begin errors++; $display("FAIL timer_r%0d_k%0d got cnt %h int_b %b want %h %b", r, k, din0, ib0, cnt_exp, ib_exp); end
            step();
        end
    endtask

    task automatic test_status_clear();
        localparam int R = 4;
        logic [15:0] cnt_exp;
        logic        pend, ib_exp, ib_next, clr;
        reset_all();
        put(IOB, 16'(R), 1'b1, 1'b0, 1'b1);
        step();
        put(IOB + 16'd2, 16'h0003, 1'b1, 1'b0, 1'b1);
        step();
        pend   = 1'b0;
        ib_exp = 1'b1;
        for (int k = 0; k < 18; k++) begin
            cnt_exp = 16'(R - (k % (R + 1)));
            clr = (k == 9) || (k == 11);
            if (clr) begin
                put(IOB + 16'd3, 16'h0001, 1'b1, 1'b0, 1'b1);
            end else if (k == 10 || k == 12) begin
                put(IOB + 16'd3, 16'h0000, 1'b0, 1'b0, 1'b1);
                checks++; if (din0 !== {15'h0000, pend}) begin errors++; $display("FAIL status_k%0d got %h want %h", k, din0, {15'h0000, pend}); end
            end else begin
                put(IOB + 16'd1, 16'h0000, 1'b0, 1'b0, 1'b1);
                checks++; if (din0 !== cnt_exp) begin errors++; $display("FAIL clr_cnt_k%0d got %h want %h", k, din0, cnt_exp); end
            end
            checks++; if (ib0 !== ib_exp) begin errors++; $display("FAIL clr_int_b_k%0d got %b want %b", k, ib0, ib_exp); end
            step();
            ib_next = !pend;
            if (cnt_exp == 16'h0000) pend = 1'b1;
            else if (clr) pend = 1'b0;
            ib_exp = ib_next;
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] a;
        reset_all();
        put(16'h0000, 16'hAAAA, 1'b1, 1'b0, 1'b1); step();
        put(IOB, 16'h0020, 1'b1, 1'b0, 1'b1); step();
        put(IOB + 16'd1, 16'h0055, 1'b1, 1'b0, 1'b1); step();
        put(IOB + 16'd1, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++; if (din0 !== 16'h0020) begin errors++; $display("FAIL count_ro got %h want 0020", din0); end
        step();
        put(16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++; if (din0 !== 16'h0000) begin errors++; $display("FAIL unmap_rd got %h want 0000", din0); end
        step();
        put(16'h8000, 16'h1234, 1'b1, 1'b0, 1'b1); step();
        put(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++; if (din0 !== 16'hAAAA) begin errors++; $display("FAIL unmap_ram got %h want aaaa", din0); end
        step();
        put(IOB, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++; if (din0 !== 16'h0020) begin errors++; $display("FAIL unmap_reload got %h want 0020", din0); end
        step();
        put(16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0);
        checks++; if (din0 !== 16'h0000) begin errors++; $display("FAIL unmap_rd2 got %h want 0000", din0); end
        step();
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom_range(16'h1000, 16'hFFEF));
            put(a, 16'h0000, 1'b0, 1'b0, 1'b1);
            checks++; if (din0 !== 16'h0000) begin errors++; $display("FAIL unmap_rand addr %h got %h want 0000", a, din0); end
            step();
        end
        put(IOB + 16'd2, 16'hFFFF, 1'b1, 1'b0, 1'b1); step();
        put(IOB + 16'd2, 16'h0000, 1'b0, 1'b0, 1'b1);
        checks++; if (din0 !== 16'h0003) begin errors++; $display("FAIL ctrl_mask got %h want 0003", din0); end
        step();
    endtask

    task automatic test_reset_mid_stall();
        localparam int WS = 2;
        reset_all();
        for (int i = 0; i <= WS; i++) begin
            put(IOB, 16'h0007, 1'b1, 1'b0, 1'b1);
            checks++; if (ce2 !== (i == WS)) begin errors++; $display("FAIL ws2_cfg_ce[%0d] got %b want %b", i, ce2, i == WS); end
            step();
        end
        for (int i = 0; i <= WS; i++) begin put(IOB + 16'd2, 16'h0003, 1'b1, 1'b0, 1'b1); step(); end
        put(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step();
        checks++; if (ib2 !== 1'b0) begin errors++; $display("FAIL ws2_pre_int_b got %b want 0", ib2); end
        put(IOB + 16'd1, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        reset_b = 1'b0;
        #1;
        checks++; if (ce2 !== 1'b0) begin errors++; $display("FAIL ws2_mid_ce got %b want 0", ce2); end
        step();
        reset_b = 1'b1;
        checks++; if (ib2 !== 1'b1) begin errors++; $display("FAIL ws2_rst_int_b got %b want 1", ib2); end
        for (int i = 0; i <= WS; i++) begin
            put(IOB + 16'd1, 16'h0000, 1'b0, 1'b0, 1'b1);
            checks++; if (ce2 !== (i == WS)) begin errors++; $display("FAIL ws2_restart_ce[%0d] got %b want %b", i, ce2, i == WS); end
            if (i == WS) begin
                checks++; if (din2 !== 16'h0000) begin errors++; $display("FAIL ws2_rst_count got %h want 0000", din2); end
            end
            step();
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i <= WS; i++) begin
                put(IOB + 16'(r), 16'h0000, 1'b0, 1'b0, 1'b1);
                if (i == WS) begin
                    checks++; if (din2 !== 16'h0000) begin errors++; $display("FAIL ws2_rst_reg%0d got %h want 0000", r, din2); end
                end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_ws0();
        test_wait_states();
        test_timer(4, 2'b11);
        test_timer(0, 2'b11);
        test_timer(int'($urandom_range(1, 9)), 2'b11);
        test_timer(int'($urandom_range(1, 9)), 2'b01);
        test_status_clear();
        test_unmapped();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
